// File: rtl/load_store_unit_if.sv
// Word-addressed memory/MMIO bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;

  modport master (output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_ready, bus_rdata);
  modport slave  (input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_ready, bus_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit: valid/ready bus with wait states, timeout and fault reporting.
// Define LSU_MISALIGN_SPLIT_EN to make misaligned accesses legal (word-crossing ones split into two beats).
module load_store_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  // Counter holds at most TIMEOUT_CYCLES-1; the final wait cycle triggers the fault.
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0]           resp_rdata_d;
  logic                  bus_valid_d, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [3:0]            bus_be_d;
  logic [31:0]           bus_wdata_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;

  logic [1:0]            off;
  logic [3:0]            size_mask;
  logic [7:0]            be_pair;
  logic [63:0]           wdata_pair;
  logic [63:0]           rd_pair;
  logic                  illegal, fault;

  assign off = req_addr[1:0];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Upper halves of the pairs are the lanes spilling into the next word.
  assign be_pair    = {4'b0000, size_mask} << off;
  assign wdata_pair = {32'h0, req_wdata} << {off, 3'b000};
  assign illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                      (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d, rd_lo_q, rd_lo_d;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
  assign fault          = illegal;
  assign rd_pair        = (state_q == BEAT2) ? {bus.bus_rdata, rd_lo_q} : {32'h0, bus.bus_rdata};
`else
  logic misaligned;
  logic unused_addr_hi;

  assign unused_addr_hi = ^{req_addr[31:ADDR_WIDTH+2], be_pair[7:4], wdata_pair[63:32]};
  assign misaligned     = (req_funct3[1:0] == 2'b01 && off[0]) ||
                          (req_funct3[1:0] == 2'b10 && off != 2'b00);
  assign fault          = illegal || misaligned;
  assign rd_pair        = {32'h0, bus.bus_rdata};
`endif

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] sh,
                                              input logic [63:0] pair);
    logic [31:0] w;
    w = 32'(pair >> {sh, 3'b000});
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    bus_valid_d  = 1'b0;
    bus_we_d     = 1'b0;
    bus_addr_d   = '0;
    bus_be_d     = 4'h0;
    bus_wdata_d  = 32'h0;
    tcnt_d       = tcnt_q;
    off_d        = off_q;
    f3_d         = f3_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    be_hi_d      = be_hi_q;
    wdata_hi_d   = wdata_hi_q;
    rd_lo_d      = rd_lo_q;
`endif

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          off_d       = off;
          f3_d        = req_funct3;
          tcnt_d      = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          be_hi_d     = be_pair[7:4];
          wdata_hi_d  = wdata_pair[63:32];
`endif
          if (fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = BEAT1;
            bus_valid_d = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = req_addr[ADDR_WIDTH+1:2];
            bus_be_d    = be_pair[3:0];
            bus_wdata_d = wdata_pair[31:0];
          end
        end
      end

      BEAT1, BEAT2: begin
        if (!bus.bus_ready) begin
          if (TIMEOUT_CYCLES != 0 && tcnt_q == T_LAST) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            tcnt_d      = tcnt_q + 1'b1;
            bus_valid_d = 1'b1;
            bus_we_d    = bus.bus_we;
            bus_addr_d  = bus.bus_addr;
            bus_be_d    = bus.bus_be;
            bus_wdata_d = bus.bus_wdata;
          end
`ifdef LSU_MISALIGN_SPLIT_EN
        end else if (state_q == BEAT1 && be_hi_q != 4'h0) begin
          // Second beat wraps around the top of the word-address space.
          state_d     = BEAT2;
          tcnt_d      = '0;
          rd_lo_d     = bus.bus_rdata;
          bus_valid_d = 1'b1;
          bus_we_d    = bus.bus_we;
          bus_addr_d  = bus.bus_addr + 1'b1;
          bus_be_d    = be_hi_q;
          bus_wdata_d = wdata_hi_q;
`endif
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!bus.bus_we) resp_rdata_d = load_extend(f3_q, off_q, rd_pair);
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'h0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'h0;
      bus.bus_wdata <= 32'h0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_err      <= resp_err_d;
      resp_rdata    <= resp_rdata_d;
      bus.bus_valid <= bus_valid_d;
      bus.bus_we    <= bus_we_d;
      bus.bus_addr  <= bus_addr_d;
      bus.bus_be    <= bus_be_d;
      bus.bus_wdata <= bus_wdata_d;
      tcnt_q        <= tcnt_d;
    end
  end

  // NOTE: request context needs no reset; it is always written at acceptance before it is read.
  always_ff @(posedge clk) begin
    off_q      <= off_d;
    f3_q       <= f3_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    be_hi_q    <= be_hi_d;
    wdata_hi_q <= wdata_hi_d;
    rd_lo_q    <= rd_lo_d;
`endif
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (ADDR_WIDTH 16, TIMEOUT_CYCLES 4).
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bif ();

  load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_bus;
    logic [15:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !req_ready; i++) step();
    check("req_ready", 32'(req_ready), 32'd1);
  endtask

  // Returns one sample after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    wait_idle();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),     32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid),    32'd0);
    check({tag, ".resp_err"},   32'(resp_err),      32'd0);
    check({tag, ".resp_rdata"}, resp_rdata,         32'd0);
    check({tag, ".bus_valid"},  32'(bif.bus_valid), 32'd0);
    check({tag, ".bus_we"},     32'(bif.bus_we),    32'd0);
    check({tag, ".bus_addr"},   32'(bif.bus_addr),  32'd0);
    check({tag, ".bus_be"},     32'(bif.bus_be),    32'd0);
    check({tag, ".bus_wdata"},  bif.bus_wdata,      32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = v.rdata;
    issue(v.we, v.f3, v.addr, v.wdata);
    if (v.exp_bus) begin
      check({v.name, ".bus_valid"},  32'(bif.bus_valid), 32'd1);
      check({v.name, ".bus_we"},     32'(bif.bus_we),    32'(v.we));
      check({v.name, ".bus_addr"},   32'(bif.bus_addr),  32'(v.exp_addr));
      check({v.name, ".bus_be"},     32'(bif.bus_be),    32'(v.exp_be));
      check({v.name, ".bus_wdata"},  bif.bus_wdata,      v.exp_wdata);
      check({v.name, ".early_resp"}, 32'(resp_valid),    32'd0);
      step();
    end
    check({v.name, ".bus_idle"},   32'(bif.bus_valid), 32'd0);
    check({v.name, ".resp_valid"}, 32'(resp_valid),    32'd1);
    check({v.name, ".resp_err"},   32'(resp_err),      32'(v.exp_err));
    check({v.name, ".resp_rdata"}, resp_rdata,         v.exp_rdata);
    step();
    check({v.name, ".resp_once"},  32'(resp_valid),    32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    int n;
    logic saw;

    vecs[0]  = '{"lw",      1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 16'h0004, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{"lb",      1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1'b1, 16'h0004, 4'b1000, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{"lbu",     1'b0, 3'b100, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1'b1, 16'h0004, 4'b1000, 32'h0,         1'b0, 32'h0000_0080};
    vecs[3]  = '{"sh",      1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b1, 16'h0008, 4'b1100, 32'hABCD_0000, 1'b0, 32'h0};
    vecs[4]  = '{"lh",      1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1'b1, 16'h0000, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001};
    vecs[5]  = '{"lhu",     1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 1'b1, 16'h0001, 4'b1100, 32'h0,         1'b0, 32'h0000_8001};
    vecs[6]  = '{"sb",      1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b1, 16'h0000, 4'b0010, 32'h0000_A500, 1'b0, 32'h0};
    vecs[7]  = '{"sw_hi",   1'b1, 3'b010, 32'h0004_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 16'h0002, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[8]  = '{"lb_pos",  1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 1'b1, 16'h0000, 4'b0001, 32'h0,         1'b0, 32'h0000_007F};
    vecs[9]  = '{"ld_011",  1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0, 16'h0000, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{"st_100",  1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055, 32'hFFFF_FFFF, 1'b0, 16'h0000, 4'b0000, 32'h0, 1'b1, 32'h0};
    vecs[11] = '{"ld_110",  1'b0, 3'b110, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0, 16'h0000, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{"st_011",  1'b1, 3'b011, 32'h0000_0010, 32'h0000_0055, 32'hFFFF_FFFF, 1'b0, 16'h0000, 4'b0000, 32'h0, 1'b1, 32'h0};
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs[13] = '{"lh_mis",  1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h00AB_CD00, 1'b1, 16'h0000, 4'b0110, 32'h0,         1'b0, 32'hFFFF_ABCD};
`else
    vecs[13] = '{"lh_mis",  1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h00AB_CD00, 1'b0, 16'h0000, 4'b0000, 32'h0,         1'b1, 32'h0};
`endif

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_funct3    = 3'b000;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("reset.ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Two wait states on a single beat: bus signals hold, response slips by two cycles.
    bif.bus_ready = 1'b0;
    bif.bus_rdata = 32'hF00D_1234;
    issue(1'b0, 3'b101, 32'h0000_001A, 32'h0);
    check("wait.bus_valid0", 32'(bif.bus_valid), 32'd1);
    step();
    check("wait.bus_valid1", 32'(bif.bus_valid), 32'd1);
    check("wait.addr_hold",  32'(bif.bus_addr),  32'h0006);
    check("wait.be_hold",    32'(bif.bus_be),    32'b1100);
    check("wait.busy",       32'(req_ready),     32'd0);
    step();
    check("wait.bus_valid2", 32'(bif.bus_valid), 32'd1);
    check("wait.no_resp",    32'(resp_valid),    32'd0);
    bif.bus_ready = 1'b1;
    step();
    check("wait.resp_valid", 32'(resp_valid),    32'd1);
    check("wait.resp_err",   32'(resp_err),      32'd0);
    check("wait.resp_rdata", resp_rdata,         32'h0000_F00D);
    step();

    // Bus never answers: four wait cycles, then fault.
    bif.bus_ready = 1'b0;
    bif.bus_rdata = 32'hFFFF_FFFF;
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    n = 0;
    while (bif.bus_valid && n < 20) begin
      n++;
      step();
    end
    check("timeout.wait_cycles", 32'(n),           32'd4);
    check("timeout.resp_valid",  32'(resp_valid),  32'd1);
    check("timeout.resp_err",    32'(resp_err),    32'd1);
    check("timeout.resp_rdata",  resp_rdata,       32'h0);
    step();
    check("timeout.resp_once",   32'(resp_valid),  32'd0);
    bif.bus_ready = 1'b1;

    // Word-crossing load at the top of the address space.
    bif.bus_rdata = 32'h1122_3344;
    issue(1'b0, 3'b010, 32'h0003_FFFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("split.b1_valid", 32'(bif.bus_valid), 32'd1);
    check("split.b1_addr",  32'(bif.bus_addr),  32'hFFFF);
    check("split.b1_be",    32'(bif.bus_be),    32'b1100);
    step();
    bif.bus_rdata = 32'h5566_7788;
    check("split.b2_valid", 32'(bif.bus_valid), 32'd1);
    check("split.b2_addr",  32'(bif.bus_addr),  32'h0000);
    check("split.b2_be",    32'(bif.bus_be),    32'b0011);
    check("split.no_resp",  32'(resp_valid),    32'd0);
    step();
    check("split.resp_valid", 32'(resp_valid), 32'd1);
    check("split.resp_err",   32'(resp_err),   32'd0);
    check("split.resp_rdata", resp_rdata,      32'h7788_1122);
`else
    check("split.no_bus",     32'(bif.bus_valid), 32'd0);
    check("split.resp_valid", 32'(resp_valid),    32'd1);
    check("split.resp_err",   32'(resp_err),      32'd1);
    check("split.resp_rdata", resp_rdata,         32'h0);
`endif
    step();

    // Reset in the middle of a stalled store beat.
    bif.bus_ready = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_0020, 32'h5A5A_5A5A);
    check("rst_mid.bus_valid", 32'(bif.bus_valid), 32'd1);
    rst = 1'b1;
    step();
    check_all_zero("rst_mid");
    rst = 1'b0;
    bif.bus_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid || bif.bus_valid) saw = 1'b1;
    end
    check("rst_mid.quiet", 32'(saw), 32'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit between the core controller and the word-addressed memory/MMIO port. Accepts one RV32I load or store per request, generates word address, byte enables and lane-shifted store data, and returns sign/zero-extended load data. Unlike the single-cycle fixed-latency memory path, it runs a valid/ready bus handshake that tolerates wait states, has a bus timeout, and reports bad or misaligned accesses.

## Interface
- ADDR_WIDTH, 16, bus word-address width; byte address bits [ADDR_WIDTH+1:2] are used, higher bits ignored
- TIMEOUT_CYCLES, 255, max cycles bus_valid may wait for bus_ready; 0 disables timeout
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: access faulted
- bus_valid  out  1  bus transfer request
- bus_ready  in  1  memory completes transfer this cycle
- bus_we  out  1  write transfer
- bus_addr  out  ADDR_WIDTH  word address
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian)
- bus_wdata  out  32  lane-shifted write data
- bus_rdata  in  32  read word, valid when bus_valid && bus_ready && !bus_we

## Operation
- States: IDLE, BEAT1, BEAT2, RESP.
- IDLE: req_ready=1. On req_valid, latch request; off=addr[1:0], size=1/2/4 from funct3[1:0].
- funct3 011/110/111, or store with funct3[2]=1: go to RESP with resp_err=1; no bus transfer.
- Misaligned = H with off[0]=1, or W with off!=0. Crossing = off+size>4.
- Aligned or non-crossing: BEAT1 only. bus_be = size-mask << off; bus_wdata = req_wdata << 8*off.
- BEAT1: bus_valid=1, signals stable until bus_ready. On bus_ready: capture read lanes; go to BEAT2 if crossing, else RESP.
- BEAT2 (split only): bus_addr = BEAT1 address + 1, wrapping modulo 2^ADDR_WIDTH; be = remaining low lanes; wdata = upper store bytes in lanes 0..; on bus_ready -> RESP.
- Load result: bytes reassembled in order, then sign-extend (B/H) or zero-extend (BU/HU).
- Timeout: counter clears at each beat start, counts cycles with bus_valid && !bus_ready; on reaching TIMEOUT_CYCLES, drop bus_valid, go to RESP with resp_err=1. A split store faulting in BEAT2 keeps BEAT1 bytes written (no rollback).
- RESP: resp_valid=1 one cycle, then IDLE. No response backpressure.

## Timing
- Reset: state IDLE; req_ready=0 during reset cycle, 1 after; resp_valid, resp_err, resp_rdata, bus_valid, bus_we, bus_addr, bus_be, bus_wdata all 0; timeout counter 0.
- Outputs registered; bus_valid asserts the cycle after acceptance.
- bus_ready tied high: accept cycle N, BEAT1 N+1, resp_valid N+2. Split: BEAT2 N+2, resp N+3. Illegal funct3: resp N+1.
- Each wait state adds one cycle per beat.
- rst mid-transfer: bus_valid drops next edge, no response issued, in-flight request discarded.
- req_valid while busy ignored (req_ready=0); core must hold it.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses legal; non-crossing use one beat with shifted lanes, crossing use BEAT1+BEAT2.
- Undefined: any misaligned access -> RESP with resp_err=1 at N+1, no bus transfer; BEAT2 logic absent.

## Test plan
- LW addr 0x0000_0010, bus_ready=1, bus_rdata 0xDEADBEEF -> bus_addr 0x0004, be 1111, resp_rdata 0xDEADBEEF at N+2, err 0.
- LB addr 0x13, rdata 0x80FF_0000 -> be 1000, resp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x22 wdata 0x1234_ABCD -> bus_we 1, be 1100, bus_wdata 0xABCD_0000.
- bus_ready held low, TIMEOUT_CYCLES=4 -> bus_valid drops after 4 wait cycles, resp_valid with err 1, rdata 0.
- With macro: LW addr 0x0003_FFFE (ADDR_WIDTH 16), beats 0xFFFF then 0x0000 returning 0x1122_3344 / 0x5566_7788 -> be 1100 then 0011, resp_rdata 0x7788_1122 at N+3. Without macro: err 1 at N+1, no bus_valid.
- funct3 011 load -> err 1 at N+1, no bus_valid; rst asserted mid BEAT1 -> all outputs 0, no resp_valid.
